// File: rtl/axil_master_port.sv
// axil_master_port: AXI4-Lite initiator fed by a request FIFO, one outstanding
// single-beat transaction at a time, completions returned on a response stream.
module axil_master_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_AW    = 2
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    output logic [FIFO_AW:0]      fifo_count,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND} state_t;
    state_t state, state_n;

    logic [EW-1:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic                  push, pop, empty;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr, addr_q, addr_n;
    logic [DATA_WIDTH-1:0] head_wdata, wdata_n, rsp_rdata_n;
    logic [STRB_WIDTH-1:0] head_wstrb, wstrb_n;
    logic                  awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n;
    logic                  rsp_valid_n, rsp_write_n;
    logic [1:0]            rsp_resp_n;

    // the MSB of the occupancy count is set only when all DEPTH entries are used
    assign req_ready = resetn && !fifo_count[FIFO_AW];
    assign empty     = fifo_count == '0;
    assign push      = req_valid && req_ready;
    assign busy      = state != IDLE || !empty;
    assign {head_write, head_addr, head_wdata, head_wstrb} = mem[rd_ptr];
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {req_write, req_addr, req_wdata, req_wstrb};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state          <= IDLE;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
        end else begin
            state          <= state_n;
            m_axil_awvalid <= awvalid_n;
            m_axil_wvalid  <= wvalid_n;
            m_axil_arvalid <= arvalid_n;
            m_axil_bready  <= bready_n;
            m_axil_rready  <= rready_n;
            rsp_valid      <= rsp_valid_n;
            rsp_write      <= rsp_write_n;
            rsp_rdata      <= rsp_rdata_n;
            rsp_resp       <= rsp_resp_n;
        end
    end

    always_ff @(posedge aclk) begin
        addr_q       <= addr_n;
        m_axil_wdata <= wdata_n;
        m_axil_wstrb <= wstrb_n;
    end

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        addr_n      = addr_q;
        wdata_n     = m_axil_wdata;
        wstrb_n     = m_axil_wstrb;
        awvalid_n   = m_axil_awvalid;
        wvalid_n    = m_axil_wvalid;
        arvalid_n   = m_axil_arvalid;
        bready_n    = m_axil_bready;
        rready_n    = m_axil_rready;
        rsp_valid_n = rsp_valid;
        rsp_write_n = rsp_write;
        rsp_rdata_n = rsp_rdata;
        rsp_resp_n  = rsp_resp;
        case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                addr_n    = head_addr;
                wdata_n   = head_wdata;
                wstrb_n   = head_wstrb;
                awvalid_n = head_write;
                wvalid_n  = head_write;
                arvalid_n = !head_write;
                state_n   = head_write ? WR_ADDR_DATA : RD_ADDR;
            end
            // AW and W retire independently; move on once neither is pending
            WR_ADDR_DATA: begin
                awvalid_n = m_axil_awvalid && !m_axil_awready;
                wvalid_n  = m_axil_wvalid && !m_axil_wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = WR_RESP;
                end
            end
            WR_RESP: if (m_axil_bvalid) begin
                bready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_write_n = 1'b1;
                rsp_rdata_n = '0;
                rsp_resp_n  = m_axil_bresp;
                state_n     = RESPOND;
            end
            RD_ADDR: if (m_axil_arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                state_n   = RD_DATA;
            end
            RD_DATA: if (m_axil_rvalid) begin
                rready_n    = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_write_n = 1'b0;
                rsp_rdata_n = m_axil_rdata;
                rsp_resp_n  = m_axil_rresp;
                state_n     = RESPOND;
            end
            RESPOND: if (rsp_ready) begin
                rsp_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_master_port.sv
// tb_axil_master_port: directed and randomized checks of axil_master_port against
// a memory-backed AXI-Lite slave and an in-order expected-response queue.
module tb_axil_master_port;
    logic        aclk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;

    always #5 aclk = ~aclk;

    axil_master_port dut (
        .aclk(aclk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .fifo_count(fifo_count),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    int   checks = 0, errors = 0, cyc = 0;
    rsp_t got[$], exp_q[$];
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];

    // slave configuration, written only by the stimulus process
    int   aw_stall = 0, w_stall = 0;
    bit   rnd_mode = 0, b_hold = 0;
    logic rsp_ready_cfg = 1'b1;
    // slave state, written only by the slave/monitor process
    int   aw_wait = 0, w_wait = 0;
    logic rnd_aw = 1'b1, rnd_w = 1'b1, rnd_ar = 1'b1, rnd_rsp = 1'b1;
    logic aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] s_addr = '0, s_data = '0, r_addr = '0;
    logic [3:0]  s_strb = '0;
    logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, prev_rv = 1'b0;
    logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;
    int   n_aw = 0, n_w = 0, n_b = 0, n_rsp = 0, proto_err = 0;
    int   aw_cyc = 0, w_cyc = 0, req_cyc = 0, rsp_rise = 0;

    assign m_axil_awready = rnd_mode ? rnd_aw : (aw_wait >= aw_stall);
    assign m_axil_wready  = rnd_mode ? rnd_w : (w_wait >= w_stall);
    assign m_axil_arready = rnd_mode ? rnd_ar : 1'b1;
    assign rsp_ready      = rnd_mode ? rnd_rsp : rsp_ready_cfg;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
        return old;
    endfunction

    // slave: responds one cycle after both AW and W (or AR) are accepted, and
    // doubles as a monitor that records handshakes and protocol stability
    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s, aw_v, w_v;
        m_axil_bvalid = 1'b0;
        m_axil_rvalid = 1'b0;
        m_axil_bresp  = 2'b00;
        m_axil_rresp  = 2'b00;
        m_axil_rdata  = '0;
        forever begin
            @(negedge aclk);
            rst_s = !resetn;
            aw_v  = m_axil_awvalid;
            w_v   = m_axil_wvalid;
            aw_hs = m_axil_awvalid && m_axil_awready;
            w_hs  = m_axil_wvalid && m_axil_wready;
            b_hs  = m_axil_bvalid && m_axil_bready;
            ar_hs = m_axil_arvalid && m_axil_arready;
            r_hs  = m_axil_rvalid && m_axil_rready;
            if (aw_pend && (!m_axil_awvalid || m_axil_awaddr != aw_prev)) proto_err++;
            if (w_pend && (!m_axil_wvalid || m_axil_wdata != w_prev)) proto_err++;
            if (ar_pend && (!m_axil_arvalid || m_axil_araddr != ar_prev)) proto_err++;
            aw_pend = !rst_s && m_axil_awvalid && !m_axil_awready;
            w_pend  = !rst_s && m_axil_wvalid && !m_axil_wready;
            ar_pend = !rst_s && m_axil_arvalid && !m_axil_arready;
            aw_prev = m_axil_awaddr;
            w_prev  = m_axil_wdata;
            ar_prev = m_axil_araddr;
            if (!rst_s) begin
                if (req_valid && req_ready) req_cyc = cyc;
                if (aw_hs) begin n_aw++; aw_cyc = cyc; end
                if (w_hs) begin n_w++; w_cyc = cyc; end
                if (b_hs) n_b++;
                if (rsp_valid && !prev_rv) rsp_rise = cyc;
                if (rsp_valid && rsp_ready) begin
                    got.push_back('{rsp_write, rsp_rdata, rsp_resp});
                    n_rsp++;
                end
            end
            prev_rv = rsp_valid;
            @(posedge aclk);
            #1;
            aw_wait = (rst_s || !aw_v || aw_hs) ? 0 : aw_wait + 1;
            w_wait  = (rst_s || !w_v || w_hs) ? 0 : w_wait + 1;
            rnd_aw  = 1'($urandom % 2);
            rnd_w   = 1'($urandom % 2);
            rnd_ar  = 1'($urandom % 2);
            rnd_rsp = 1'($urandom % 2);
            if (rst_s) begin
                aw_got = 1'b0;
                w_got  = 1'b0;
                m_axil_bvalid = 1'b0;
                m_axil_rvalid = 1'b0;
            end else begin
                if (b_hs) m_axil_bvalid = 1'b0;
                if (r_hs) m_axil_rvalid = 1'b0;
                if (aw_hs) begin aw_got = 1'b1; s_addr = m_axil_awaddr; end
                if (w_hs) begin w_got = 1'b1; s_data = m_axil_wdata; s_strb = m_axil_wstrb; end
                if (aw_got && w_got && !b_hold && !m_axil_bvalid) begin
                    smem[s_addr]  = merge(smem.exists(s_addr) ? smem[s_addr] : '0, s_data, s_strb);
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = s_addr[13:12];
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (ar_hs) begin
                    r_addr = m_axil_araddr;
                    m_axil_rvalid = 1'b1;
                    m_axil_rdata  = smem.exists(r_addr) ? smem[r_addr] : '0;
                    m_axil_rresp  = r_addr[13:12];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    // the slave answers with a response code taken from address bits 13:12
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit ok);
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            if (req_ready) ok = 1;
            @(posedge aclk);
            #1;
        end
        req_valid = 1'b0;
        if (ok) begin
            rsp_t e;
            e.wr   = w;
            e.resp = a[13:12];
            if (w) begin
                mmem[a] = merge(mmem.exists(a) ? mmem[a] : '0, d, s);
                e.data  = '0;
            end else e.data = mmem.exists(a) ? mmem[a] : '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_rsp(input string tag);
        rsp_t g, e;
        int n = 0;
        while (got.size() == 0 && n < 300) begin tick(1); n++; end
        check({tag, ".present"}, 64'(got.size() > 0), 1);
        if (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            check({tag, ".write"}, g.wr, e.wr);
            check({tag, ".rdata"}, g.data, e.data);
            check({tag, ".resp"}, g.resp, e.resp);
        end
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        bit ok;
        int acc, b0, w0, a0, n0;
        resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        tick(3);
        check("reset.req_ready", req_ready, 0);
        check("reset.valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, rsp_valid}, 0);
        check("reset.rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
        check("reset.count", fifo_count, 0);
        check("reset.busy", busy, 0);
        check("prot", {m_axil_awprot, m_axil_arprot}, 0);
        resetn = 1'b1;
        tick(1);
        check("idle.req_ready", req_ready, 1);

        send(1, 32'h10, 32'hDEAD_BEEF, 4'hF, ok);
        check("wr.accepted", ok, 1);
        expect_rsp("wr");
        check("wr.aw_lat", aw_cyc - req_cyc, 2);
        check("wr.w_lat", w_cyc - req_cyc, 2);
        check("wr.rsp_lat", rsp_rise - req_cyc, 4);

        send(0, 32'h10, '0, '0, ok);
        expect_rsp("rd");
        check("rd.rsp_lat", rsp_rise - req_cyc, 4);

        aw_stall = 3;
        b0 = n_b; w0 = n_w; a0 = n_aw; n0 = n_rsp;
        send(1, 32'h24, 32'h1234_5678, 4'b0101, ok);
        expect_rsp("split");
        check("split.w_cyc", w_cyc - req_cyc, 2);
        check("split.aw_cyc", aw_cyc - req_cyc, 5);
        check("split.n_aw", n_aw - a0, 1);
        check("split.n_w", n_w - w0, 1);
        check("split.n_b", n_b - b0, 1);
        aw_stall = 0;
        tick(5);
        check("split.n_rsp", n_rsp - n0, 1);
        send(0, 32'h24, '0, '0, ok);
        expect_rsp("strb_rd");

        rsp_ready_cfg = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(logic'(i % 2 == 0), 32'h100 + 32'(4 * i), 32'hA500_0000 + 32'(i), 4'hF, ok);
            if (ok) acc++;
        end
        check("full.accepted", acc, 5);
        check("full.count", fifo_count, 4);
        check("full.req_ready", req_ready, 0);
        rsp_ready_cfg = 1'b1;
        for (int i = 0; i < 5; i++) expect_rsp($sformatf("full%0d", i));

        send(1, 32'h2000, 32'hCAFE_F00D, 4'hF, ok);
        send(0, 32'h3000, '0, '0, ok);
        expect_rsp("err_wr");
        expect_rsp("err_rd");
        check("err.busy", busy, 0);

        b_hold = 1;
        send(1, 32'h40, 32'h1111_1111, 4'hF, ok);
        send(0, 32'h44, '0, '0, ok);
        send(1, 32'h48, 32'h2222_2222, 4'hF, ok);
        tick(3);
        check("mid.count", fifo_count, 2);
        check("mid.bready", m_axil_bready, 1);
        resetn = 1'b0;
        #1;
        check("mid.req_ready_in_reset", req_ready, 0);
        tick(1);
        resetn = 1'b1;
        check("mid.valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready, rsp_valid}, 0);
        check("mid.count0", fifo_count, 0);
        check("mid.busy", busy, 0);
        b_hold = 0;
        exp_q.delete();
        n0 = n_rsp;
        tick(10);
        check("mid.no_rsp", n_rsp - n0, 0);
        got.delete();

        rnd_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom % 2), (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2),
                 $urandom, 4'($urandom_range(0, 15)), ok);
            check("rnd.accepted", ok, 1);
            tick($urandom_range(0, 2));
        end
        while (exp_q.size() > 0) expect_rsp("rnd");
        rnd_mode = 0;
        tick(3);
        check("rnd.busy", busy, 0);
        check("proto_stable", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
